// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner.
//   - ch_state_e : 2-bit per-channel debounce state encoding
//   - NumBtn     : number of button channels
//   - DefDebounceCycles / DefSyncStages : default parameter values
package button_conditioner_pkg;

   localparam int unsigned NumBtn            = 3;
   localparam int unsigned DefDebounceCycles = 16;
   localparam int unsigned DefSyncStages     = 2;

   typedef enum logic [1:0] {
      StIdleLow  = 2'd0,
      StWaitHigh = 2'd1,
      StIdleHigh = 2'd2,
      StWaitLow  = 2'd3
   } ch_state_e;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// Single button channel: SYNC_STAGES-deep synchronizer followed by a debounce FSM
// with a stability counter, plus an optional rising-edge pulse register.
// Optional feature macro: BTN_PULSE_EN (builds the pulse register).
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   raw_i   - raw asynchronous button level
//   b_o     - debounced, registered level
//   pulse_o - one-cycle pulse after each accepted 0->1 commit (0 when pulse logic absent)
module debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned SYNC_STAGES     = DefSyncStages
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic b_o,
   output logic pulse_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   ch_state_e              state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   cnt_done;

   // Synchronizer: bit 0 samples the raw input, the top bit feeds the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign cnt_done = (cnt_q == CntMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdleLow;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdleLow: begin
            if (s) begin
               state_d = StWaitHigh;
               cnt_d   = '0;
            end
         end
         StWaitHigh: begin
            if (!s) begin
               state_d = StIdleLow;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = StIdleHigh;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StIdleHigh: begin
            if (!s) begin
               state_d = StWaitLow;
               cnt_d   = '0;
            end
         end
         StWaitLow: begin
            if (s) begin
               state_d = StIdleHigh;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = StIdleLow;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StIdleLow;
            cnt_d   = '0;
         end
      endcase
   end

   // The accepted level is high exactly in IdleHigh and WaitLow (state bit 1),
   // so b comes straight from the state register.
   assign b_o = state_q[1];

`ifdef BTN_PULSE_EN
   logic pulse_q;
   logic rise_commit;

   assign rise_commit = (state_q == StWaitHigh) && s && cnt_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= rise_commit;
      end
   end

   assign pulse_o = pulse_q;
`else
   assign pulse_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Three-channel button conditioner: turns raw bouncing buttons into clean,
// clock-synchronous levels b[3:1] for the downstream button state machine.
// Optional feature macro: BTN_PULSE_EN (enables b_pulse; otherwise tied to 0).
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   btn_raw - raw asynchronous button levels [3:1]
//   b       - debounced, registered levels [3:1]
//   b_pulse - one-cycle pulse per accepted 0->1 transition of b [3:1]
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned SYNC_STAGES     = DefSyncStages
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NumBtn:1]   btn_raw,
   output logic [NumBtn:1]   b,
   output logic [NumBtn:1]   b_pulse
);

   for (genvar i = 1; i <= NumBtn; i++) begin : gen_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw_i   (btn_raw[i]),
         .b_o     (b[i]),
         .pulse_o (b_pulse[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

`ifdef BTN_PULSE_EN
   localparam bit PulseEn = 1'b1;
`else
   localparam bit PulseEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:1] btn_raw;
   logic [3:1] b;
   logic [3:1] b_pulse;

   int vectors    = 0;
   int miscompares = 0;
   int pcnt [1:3] = '{0, 0, 0};

   button_conditioner dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw),
      .b       (b),
      .b_pulse (b_pulse)
   );

   always #50 clk = ~clk;

   // Running count of pulse cycles per channel.
   always @(posedge clk) begin
      for (int i = 1; i <= 3; i++) pcnt[i] <= pcnt[i] + int'(b_pulse[i]);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int snap [1:3];
      logic [2:0] prev;
      logic [2:0] v;

      // Reset state
      rst_n   = 1'b0;
      btn_raw = 3'b000;
      tick(2);
      check("reset_b", b, 3'b000);
      check("reset_pulse", b_pulse, 3'b000);
      rst_n = 1'b1;
      tick(3);
      check("idle_b", b, 3'b000);

      // Clean press on channel 1
      snap = pcnt;
      btn_raw = 3'b001;
      tick(18);
      check("press_edge18_b", b, 3'b000);
      tick(1);
      check("press_edge19_b", b, 3'b001);
      check("press_edge19_pulse", b_pulse, PulseEn ? 3'b001 : 3'b000);
      tick(1);
      check("press_edge20_pulse", b_pulse, 3'b000);
      tick(4);
      check("press_hold_b", b, 3'b001);
      check_int("press_pulse_count", pcnt[1] - snap[1], PulseEn ? 1 : 0);
      btn_raw = 3'b000;
      tick(18);
      check("rel1_edge18_b", b, 3'b001);
      tick(1);
      check("rel1_edge19_b", b, 3'b000);
      tick(5);

      // Glitch on channel 2: 10 cycles high is too short
      snap = pcnt;
      btn_raw = 3'b010;
      tick(10);
      btn_raw = 3'b000;
      tick(5);
      check("glitch_mid_b", b, 3'b000);
      tick(25);
      check("glitch_b", b, 3'b000);
      check_int("glitch_pulse_count", pcnt[2] - snap[2], 0);

      // Bounce on channel 3, then hold
      snap = pcnt;
      btn_raw = 3'b100; tick(3);
      btn_raw = 3'b000; tick(3);
      btn_raw = 3'b100; tick(3);
      btn_raw = 3'b000; tick(3);
      btn_raw = 3'b100;
      tick(18);
      check("bounce_edge18_b", b, 3'b000);
      tick(1);
      check("bounce_edge19_b", b, 3'b100);
      tick(5);
      check_int("bounce_pulse_count", pcnt[3] - snap[3], PulseEn ? 1 : 0);

      // All pressed, then simultaneous release
      btn_raw = 3'b111;
      tick(19);
      check("all_press_b", b, 3'b111);
      tick(6);
      snap = pcnt;
      btn_raw = 3'b000;
      tick(18);
      check("all_rel_edge18_b", b, 3'b111);
      tick(1);
      check("all_rel_edge19_b", b, 3'b000);
      check("all_rel_pulse", b_pulse, 3'b000);
      tick(5);
      check_int("all_rel_pulses", (pcnt[1] - snap[1]) + (pcnt[2] - snap[2])
                + (pcnt[3] - snap[3]), 0);

      // Reset in the middle of WaitHigh, button held through it
      btn_raw = 3'b001;
      tick(12);
      rst_n = 1'b0;
      #1;
      check("rst_wait_b", b, 3'b000);
      tick(2);
      rst_n = 1'b1;
      tick(18);
      check("rst_wait_edge18_b", b, 3'b000);
      tick(1);
      check("rst_wait_edge19_b", b, 3'b001);
      check("rst_wait_edge19_pulse", b_pulse, PulseEn ? 3'b001 : 3'b000);

      // Reset while in IdleHigh / with pulse live: outputs clear asynchronously
      #20;
      rst_n = 1'b0;
      #1;
      check("rst_high_b", b, 3'b000);
      check("rst_high_pulse", b_pulse, 3'b000);
      btn_raw = 3'b000;
      tick(2);
      rst_n = 1'b1;
      tick(3);

      // Sweep 0..7
      prev = 3'b000;
      for (int k = 0; k < 8; k++) begin
         v = 3'(k);
         btn_raw = v;
         tick(18);
         check("sweep_edge18_b", b, prev);
         tick(1);
         check("sweep_edge19_b", b, v);
         check("sweep_edge19_pulse", b_pulse, PulseEn ? (v & ~prev) : 3'b000);
         tick(5);
         prev = v;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
